// File: rtl/spu_fetch_pair_stage.sv
// SPU dual-issue fetch: PC register, pair read from local imem,
// and the IF/ID register feeding the decoder.
module spu_fetch_pair_stage #(
  parameter int PC_WIDTH   = 11,
  parameter int IMEM_WORDS = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [PC_WIDTH-1:0]           pc_if,
  output logic [31:0]                   inst0_id,
  output logic [31:0]                   inst1_id,
  output logic                          valid0_id,
  output logic                          valid1_id,
  output logic [PC_WIDTH-1:0]           pc_id,
  output logic [PC_WIDTH-1:0]           pc_plus8_id
);

  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [PC_WIDTH-1:0] PC_FOUR  = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] PC_EIGHT = PC_WIDTH'(8);
  localparam logic [AW-1:0]       IDX_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0]         inst0;
    logic [31:0]         inst1;
    logic                valid0;
    logic                valid1;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus8;
  } if_id_t;

  logic [31:0]         mem_q [IMEM_WORDS];
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  if_id_t              if_id_q;
  if_id_t              if_id_d;

  logic [AW-1:0]       rd_idx0;
  logic [AW-1:0]       rd_idx1;
  logic [31:0]         rd_inst0;
  logic [31:0]         rd_inst1;
  logic                odd_word;
  logic [PC_WIDTH-1:0] pc_step;
  logic [PC_WIDTH-1:0] redir_tgt;
  logic                unused_rpc;

  // Slot-1 index wraps within the memory, matching PC wrap.
  assign rd_idx0  = pc_q[AW+1:2];
  assign rd_idx1  = rd_idx0 + IDX_ONE;
  assign rd_inst0 = mem_q[rd_idx0];
  assign rd_inst1 = mem_q[rd_idx1];

  assign odd_word   = pc_q[2];
  assign pc_step    = odd_word ? PC_FOUR : PC_EIGHT;
  assign redir_tgt  = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    priority case (1'b1)
      reset: begin
        pc_d    = '0;
        if_id_d = '0;
      end
      redirect_valid: begin
        pc_d           = redir_tgt;
        if_id_d.inst0  = '0;
        if_id_d.inst1  = '0;
        if_id_d.valid0 = 1'b0;
        if_id_d.valid1 = 1'b0;
      end
      stall: begin
      end
      default: begin
        pc_d             = pc_q + pc_step;
        if_id_d.inst0    = rd_inst0;
        if_id_d.inst1    = rd_inst1;
        if_id_d.valid0   = 1'b1;
        if_id_d.valid1   = ~odd_word;
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus8 = pc_q + PC_EIGHT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    if_id_q <= if_id_d;
  end

  // Writes land at the edge, so a same-cycle fetch sees old data.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem_q[imem_waddr] <= imem_wdata;
    end
  end

  assign pc_if       = pc_q;
  assign inst0_id    = if_id_q.inst0;
  assign inst1_id    = if_id_q.inst1;
  assign valid0_id   = if_id_q.valid0;
  assign valid1_id   = if_id_q.valid1;
  assign pc_id       = if_id_q.pc;
  assign pc_plus8_id = if_id_q.pc_plus8;

endmodule

// File: tb/tb_spu_fetch_pair_stage.sv
// Directed bench for spu_fetch_pair_stage with an expectation queue
// filled as each step is driven and drained after each edge.
module tb_spu_fetch_pair_stage;

  typedef struct {
    logic [10:0] pc_if;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        v0;
    logic        v1;
    logic [10:0] pc_id;
    logic [10:0] pc8;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_pc = '0;
  logic        imem_we = 1'b0;
  logic [8:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [10:0] pc_if;
  logic [31:0] inst0_id;
  logic [31:0] inst1_id;
  logic        valid0_id;
  logic        valid1_id;
  logic [10:0] pc_id;
  logic [10:0] pc_plus8_id;

  logic [31:0] tmem [512];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  spu_fetch_pair_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .pc_if          (pc_if),
    .inst0_id       (inst0_id),
    .inst1_id       (inst1_id),
    .valid0_id      (valid0_id),
    .valid1_id      (valid1_id),
    .pc_id          (pc_id),
    .pc_plus8_id    (pc_plus8_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input string f,
                     input logic [31:0] obs, input logic [31:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, ex);
    end
  endtask

  task automatic exp_rst();
    exp_t e;
    e = '{11'd0, 32'd0, 32'd0, 1'b0, 1'b0, 11'd0, 11'd0};
    sb.push_back(e);
  endtask

  task automatic exp_pair(input int pcif, input int pcid, input bit v1);
    exp_t e;
    int   w;
    w = pcid / 4;
    e.pc_if = 11'(pcif);
    e.inst0 = tmem[w];
    e.inst1 = tmem[(w + 1) % 512];
    e.v0    = 1'b1;
    e.v1    = v1;
    e.pc_id = 11'(pcid);
    e.pc8   = 11'((pcid + 8) % 2048);
    sb.push_back(e);
  endtask

  task automatic exp_bub(input int pcif, input int pcid, input int pc8);
    exp_t e;
    e = '{11'(pcif), 32'd0, 32'd0, 1'b0, 1'b0, 11'(pcid), 11'(pc8)};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    exp_t e;
    tick();
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp(tag, "pc_if", 32'(pc_if), 32'(e.pc_if));
      cmp(tag, "inst0", inst0_id, e.inst0);
      cmp(tag, "inst1", inst1_id, e.inst1);
      cmp(tag, "valid0", 32'(valid0_id), 32'(e.v0));
      cmp(tag, "valid1", 32'(valid1_id), 32'(e.v1));
      cmp(tag, "pc_id", 32'(pc_id), 32'(e.pc_id));
      cmp(tag, "pc8", 32'(pc_plus8_id), 32'(e.pc8));
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 9'(i);
      imem_wdata = (i < 4) ? 32'h1111_1111 * (i + 1)
                           : (32'hA500_0000 | 32'(i));
      tmem[i]    = imem_wdata;
      tick();
    end
    imem_we = 1'b0;
    exp_rst();
    step("reset");

    reset = 1'b0;
    exp_pair(8, 0, 1);
    step("pair0");
    exp_pair(16, 8, 1);
    step("pair1");

    redirect_valid = 1'b1;
    redirect_pc    = 11'h017;
    exp_bub(20, 8, 16);
    step("redir_bub");
    redirect_valid = 1'b0;
    exp_pair(24, 20, 0);
    step("redir_odd");
    exp_pair(32, 24, 1);
    step("realign");

    stall      = 1'b1;
    imem_we    = 1'b1;
    imem_waddr = 9'd8;
    imem_wdata = 32'hDEAD_BEEF;
    exp_pair(32, 24, 1);
    step("stall0");
    tmem[8] = 32'hDEAD_BEEF;
    imem_we = 1'b0;
    exp_pair(32, 24, 1);
    step("stall1");
    exp_pair(32, 24, 1);
    step("stall2");

    stall      = 1'b0;
    imem_we    = 1'b1;
    imem_waddr = 9'd8;
    imem_wdata = 32'hCAFE_F00D;
    exp_pair(40, 32, 1);
    step("release");
    tmem[8] = 32'hCAFE_F00D;
    imem_we = 1'b0;

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h100;
    exp_bub(11'h100, 32, 40);
    step("stall_redir");
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exp_pair(11'h108, 11'h100, 1);
    step("tgt100");

    redirect_valid = 1'b1;
    redirect_pc    = 11'h7F8;
    exp_bub(11'h7F8, 11'h100, 11'h108);
    step("redir7f8");
    redirect_valid = 1'b0;
    exp_pair(0, 11'h7F8, 1);
    step("wrap_pair");

    redirect_valid = 1'b1;
    redirect_pc    = 11'h7FC;
    exp_bub(11'h7FC, 11'h7F8, 0);
    step("redir7fc");
    redirect_valid = 1'b0;
    exp_pair(0, 11'h7FC, 0);
    step("wrap_odd");
    exp_pair(8, 0, 1);
    step("after_wrap");

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h200;
    reset          = 1'b1;
    exp_rst();
    step("reset_mid");
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exp_pair(8, 0, 1);
    step("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spu_fetch_pair_stage.md
# spu_fetch_pair_stage

Dual-issue instruction fetch stage for the SPU pipeline: holds the program counter, reads an aligned instruction pair from an internal instruction memory, and registers the pair into the IF/ID boundary consumed by the decoder. It supports stall (hold), branch redirect with wrong-path flush, and single-slot fetch when the PC is not pair-aligned. It also provides a write port for loading the instruction memory.

## Interface
- PC_WIDTH, 11, byte-address width of PC; wraps modulo 2^PC_WIDTH
- IMEM_WORDS, 512, 32-bit words in instruction memory (= 2^PC_WIDTH / 4)
- Ports (clock and reset first):
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  hold PC and IF/ID registers this cycle
- redirect_valid  input  1  branch taken; load PC from redirect_pc
- redirect_pc  input  PC_WIDTH  branch target byte address; bits [1:0] ignored
- imem_we  input  1  instruction memory write enable
- imem_waddr  input  log2(IMEM_WORDS)  word address for write
- imem_wdata  input  32  write data
- pc_if  output  PC_WIDTH  current fetch PC (debug/observe)
- inst0_id  output  32  slot-0 instruction (word at PC)
- inst1_id  output  32  slot-1 instruction (word at PC+4)
- valid0_id  output  1  slot 0 holds a real instruction
- valid1_id  output  1  slot 1 holds a real instruction
- pc_id  output  PC_WIDTH  byte address of slot 0
- pc_plus8_id  output  PC_WIDTH  pc_id + 8 mod 2^PC_WIDTH (link value)

## Operation
- Reset: pc_if = 0; inst0_id = inst1_id = 0; valid0_id = valid1_id = 0; pc_id = 0; pc_plus8_id = 0. Memory contents are not cleared.
- Memory read is combinational, indexed by word address w = pc_if[PC_WIDTH-1:2]. Slot-1 index is (w+1) mod IMEM_WORDS.
- Normal cycle (no reset, no redirect, no stall):
  - IF/ID loads inst0 = mem[w], inst1 = mem[w+1], pc_id = pc_if, and pc_plus8_id = pc_if+8.
  - valid0_id = 1; valid1_id = ~pc_if[2].
  - Next PC: pc_if+8 if pc_if[2]=0; otherwise pc_if+4. The PC therefore realigns to a pair boundary after an odd-word fetch.
  - All PC arithmetic is modulo 2^PC_WIDTH.
- Redirect (redirect_valid=1):
  - pc_if <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - IF/ID is flushed: valid0_id = valid1_id = 0, inst0_id = inst1_id = 0. pc_id and pc_plus8_id hold.
- Stall (stall=1, redirect_valid=0): all state holds.
- Priority: reset > redirect_valid > stall > normal. A redirect asserted during a stall takes effect and clears the stall effect for that edge.
- Write port: when imem_we=1, mem[imem_waddr] <= imem_wdata at the clock edge. A fetch in the same cycle from the same word returns the old data. Writes are honoured during reset and stall.
- No internal state machine beyond PC/IF-ID; the "state" is {pc_if, valid bits}.

## Timing
- Fetch latency: PC value present in cycle n appears in the *_id outputs after edge n+1 (1 cycle).
- Redirect penalty: the redirect edge produces one bubble (valids=0). The target pair is registered at the following edge.
- Reset deassert at edge k: pc_if = 0 during cycle k; the first valid pair (addresses 0 and 4) appears after edge k+1.
- Reset mid-operation: on the next edge, all outputs return to reset values regardless of stall or redirect.
- Wrap-around: pc_if = 2^PC_WIDTH-8 fetches words IMEM_WORDS-2 and IMEM_WORDS-1, and the next PC is 0. If pc_if = 2^PC_WIDTH-4 (odd word), slot-1 index wraps to 0 (valid1_id=0) and the next PC is 0.
- Stall held for N cycles: outputs are stable for N cycles; no instruction is duplicated or dropped.

## Test plan
- Reset, load mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444, release: after edge 1 inst0/1 = 0x11111111/0x22222222, valids=1/1, pc_id=0, pc_plus8_id=8; after edge 2 pair 0x33333333/0x44444444, pc_id=8.
- Redirect to 0x014 at pc_if=0x010: next edge valids=0/0 and pc_if=0x014. Following edge inst0 = mem[5], valid1_id=0, pc_id=0x014. Next pc_if = 0x018.
- Stall for 3 cycles mid-stream: *_id outputs and pc_if remain constant for 3 edges. On release, the sequence resumes with no gap or repeat.
- Stall and redirect to 0x100 together: redirect wins, giving pc_if=0x100 and valids=0 after the edge.
- Wrap: redirect to 0x7F8 loads pair mem[510]/mem[511] with valids 1/1, then pc_if=0x000. Redirect to 0x7FC gives valid1_id=0, then pc_if=0x000.
- Assert reset while valids=1 and stall=1: after the edge all outputs are 0 and pc_if=0.
